// File: rtl/spart_send_queue_pkg.sv
// Shared types for the SPART send path: field widths, queued entry layout,
// and the drain state encoding.
//   Contents: SPART_ADDR_W, SPART_DATA_W, SPART_ENTRY_W, spart_entry_t, drain_state_e.
package spart_send_queue_pkg;

  localparam int SPART_ADDR_W  = 3;
  localparam int SPART_DATA_W  = 8;
  localparam int SPART_ENTRY_W = SPART_ADDR_W + SPART_DATA_W;

  // Address sits in the upper bits so a raw entry reads as {addr, data}.
  typedef struct packed {
    logic [SPART_ADDR_W-1:0] addr;
    logic [SPART_DATA_W-1:0] data;
  } spart_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } drain_state_e;

endpackage

// File: rtl/spart_send_queue_fifo.sv
// Purpose: generic synchronous FIFO; holds storage, wrapping pointers and occupancy count.
// Latency: a pushed word is visible at head_dat after the push edge; no write-to-read bypass.
// Backpressure: push while full and pop while empty are ignored; full/empty decode registered count.
//   Ports: clk, rst (sync, active-high), push/push_dat, pop, head_dat, count, full, empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a push is dropped while full
  // even if a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spart_send_queue.sv
// Purpose: buffers execute-stage SPART send requests and drains them to the SPART tx port.
// Latency: push at edge k is presented (tx_valid) after edge k+1; one entry per cycle while tx_ready.
// Backpressure: full stalls the pipeline (pushes while full dropped, ovf sticky); !tx_ready holds outputs.
//   Ports: clk, rst (sync, active-high); send/spart_addr/send_data in; full, count, ovf, idle status;
//   tx_valid/tx_addr/tx_data/tx_ready handshake toward the SPART.
module spart_send_queue
  import spart_send_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send,
  input  logic [SPART_ADDR_W-1:0]    spart_addr,
  input  logic [SPART_DATA_W-1:0]    send_data,
  output logic                       full,
  output logic                       tx_valid,
  output logic [SPART_ADDR_W-1:0]    tx_addr,
  output logic [SPART_DATA_W-1:0]    tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       idle
);

  drain_state_e            state_q, state_d;
  logic [SPART_ADDR_W-1:0] tx_addr_q, tx_addr_d;
  logic [SPART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                    ovf_q, ovf_d;

  spart_entry_t push_ent;
  spart_entry_t head_ent;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;

  assign push_ent.addr = spart_addr;
  assign push_ent.data = send_data;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SPART_ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (send),
    .push_dat (push_ent),
    .pop      (fifo_pop),
    .head_dat (head_ent),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Drain control: the output register is reloaded from the FIFO head either
  // when leaving IDLE or when the presented entry is accepted.
  always_comb begin
    state_d   = state_q;
    tx_addr_d = tx_addr_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          tx_addr_d = head_ent.addr;
          tx_data_d = head_ent.data;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tx_ready) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            tx_addr_d = head_ent.addr;
            tx_data_d = head_ent.data;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  assign ovf_d = ovf_q || (send && fifo_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_addr_q <= '0;
      tx_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_addr_q <= tx_addr_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign full     = fifo_full;
  assign tx_valid = (state_q == ST_HOLD);
  assign tx_addr  = tx_addr_q;
  assign tx_data  = tx_data_q;
  assign ovf      = ovf_q;
  assign idle     = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: doc/spart_send_queue.md
# spart_send_queue

Transmit-side endpoint for the processor's SPART send path: accepts send requests (3-bit SPART register address + 8-bit data) retired by the execute stage, buffers them in a small FIFO, and drains them to the SPART transmit port with a valid/ready handshake. Its `full` output is the back-pressure signal the pipeline uses to stall and hold a pending send. It sits between the EX/MEM boundary of the core and the SPART peripheral.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `send` in 1 — push request from execute stage
- `spart_addr` in 3 — SPART register address of the request
- `send_data` in 8 — byte to send
- `full` out 1 — FIFO holds DEPTH entries; pipeline must stall
- `tx_valid` out 1 — output register holds an entry for SPART
- `tx_addr` out 3 — address of presented entry
- `tx_data` out 8 — data of presented entry
- `tx_ready` in 1 — SPART accepts presented entry this cycle
- `count` out clog2(DEPTH+1) — entries in FIFO (excludes output register)
- `ovf` out 1 — sticky: a push was attempted while full
- `idle` out 1 — FIFO empty and output register empty

## Operation
- Entry = {spart_addr, send_data}, 11 bits, stored in order.
- Push: `send && !full` writes entry at tail, count+1. `send && full` drops entry, sets `ovf`; count unchanged.
- `full` = (count == DEPTH), decoded from registered count; no look-through: push while full is dropped even if a pop occurs in the same cycle.
- Drain FSM, two states:
  - IDLE: `tx_valid`=0. If count>0: load head into output register, pop, → HOLD.
  - HOLD: `tx_valid`=1, `tx_addr/tx_data` stable. If `tx_ready`: if count>0 load next head and pop, stay HOLD; else → IDLE. If `!tx_ready`: hold all outputs.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `idle` = (state==IDLE) && (count==0).
- `ovf` cleared only by `rst`.
- `tx_ready` in IDLE is ignored.

## Timing
- Reset (rst high at an edge): state=IDLE, pointers=0, count=0, `full`=0, `tx_valid`=0, `tx_addr`=0, `tx_data`=0, `ovf`=0, `idle`=1. Reset mid-transfer discards all queued and presented entries; no transfer completes on the reset edge.
- Latency: push accepted at edge k → `tx_valid`=1 with that entry after edge k+1 (one cycle FIFO residence; no bypass).
- Throughput: one entry per cycle while `tx_ready` held high and FIFO non-empty.
- `full` rises after the edge that stores the DEPTH-th entry; falls after the first pop edge from full.
- A transfer completes at the edge where `tx_valid && tx_ready`; `tx_addr/tx_data` change only at that edge or on leaving IDLE.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.

## Structure
- Shared package: `SPART_ADDR_W`=3, `SPART_DATA_W`=8, entry width constant, drain-state enum (IDLE, HOLD).
- Sub-module `sync_fifo` (DEPTH, WIDTH params; push/pop/head/count/full/empty, synchronous reset) holds storage and pointers; top level holds output register, FSM, `ovf`.

## Test plan
- Reset: hold rst 2 cycles with send=1 → count=0, tx_valid=0, idle=1, ovf=0, full=0.
- Single push {addr=3'h4, data=8'hA5} at edge k, tx_ready=1 → tx_valid=1, tx_addr=4, tx_data=A5 after edge k+1; transfer at edge k+2; idle=1 after k+2.
- Fill with tx_ready=0: push 5 entries (data 01..05), DEPTH=4 → first entry in output register, count=4, full=1, ovf=0; push of 06 → dropped, ovf=1; then tx_ready=1 → SPART sees 01,02,03,04,05 on consecutive edges, 06 never appears.
- Back-pressure: tx_ready toggles 1,0,0,1 while 3 entries queued → tx_data stable across low cycles, order preserved, no duplicates.
- Simultaneous push and pop with count=2 → count stays 2; run 10 such cycles to force pointer wrap, data order intact.
- Reset in HOLD with count=3 → next cycle tx_valid=0, count=0; subsequent push delivered normally.
